// File: rtl/display_arbiter.sv
// display_arbiter
//   Shares the eight-digit seven-segment display between two requesters.
//   Round-robin arbitration with a minimum dwell time per owner. Dwell is
//   measured in prescaled ticks. The block sits directly in front of
//   eight_display and drives its seg0..seg7 inputs.
//
// Ports
//   ck           system clock; all state updates on posedge ck
//   rst          synchronous reset, active-high
//   req0, req1   level requests, held for the whole period of use
//   data0, data1 packed digit codes: [3:0]=seg0 ... [31:28]=seg7
//   gnt0, gnt1   registered ownership flags; at most one is set
//   busy         gnt0 | gnt1
//   seg0..seg7   registered digit codes; BLANK when nobody owns the display
module display_arbiter #(
    parameter logic [26:0] TICK_DIV = 27'd49_999_999,
    parameter logic [3:0]  DWELL    = 4'd4,
    parameter logic [3:0]  BLANK    = 4'h0
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] data0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic [3:0]  seg0,
    output logic [3:0]  seg1,
    output logic [3:0]  seg2,
    output logic [3:0]  seg3,
    output logic [3:0]  seg4,
    output logic [3:0]  seg5,
    output logic [3:0]  seg6,
    output logic [3:0]  seg7
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [26:0] tick_cnt;
    logic        tick;
    logic [3:0]  dwell;
    logic        last;       // last-served requester
    logic        dwell_done;
    logic [31:0] seg_q;
    logic [31:0] seg_nxt;

    assign tick       = (tick_cnt == TICK_DIV);
    assign dwell_done = (dwell == DWELL);

    // NOTE: every output of this block is assigned a default first,
    // so no path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (!req0)
                    state_nxt = req1 ? OWN1 : IDLE;
                else if (req1 && dwell_done)
                    state_nxt = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_nxt = req0 ? OWN0 : IDLE;
                else if (req0 && dwell_done)
                    state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Segments follow the next-state owner, so the digits and gnt change together.
    always_comb begin
        case (state_nxt)
            OWN0:    seg_nxt = data0;
            OWN1:    seg_nxt = data1;
            default: seg_nxt = {8{BLANK}};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples values from before the edge, whatever the statement order.
    always_ff @(posedge ck) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            tick_cnt <= '0;
            dwell    <= '0;
            last     <= 1'b1;
            seg_q    <= {8{BLANK}};
        end else begin
            // The prescaler free-runs and grants never reset it.
            tick_cnt <= tick ? '0 : tick_cnt + 27'd1;
            state    <= state_nxt;
            gnt0     <= (state_nxt == OWN0);
            gnt1     <= (state_nxt == OWN1);
            seg_q    <= seg_nxt;

            // On entry to a new owner, dwell restarts at 0 and any tick
            // on that same edge is discarded.
            if (state_nxt == IDLE) begin
                dwell <= '0;
            end else if (state_nxt != state) begin
                dwell <= '0;
                last  <= (state_nxt == OWN1);
            end else if (tick && !dwell_done) begin
                dwell <= dwell + 4'd1;
            end
        end
    end

    assign busy = gnt0 | gnt1;

    assign seg0 = seg_q[3:0];
    assign seg1 = seg_q[7:4];
    assign seg2 = seg_q[11:8];
    assign seg3 = seg_q[15:12];
    assign seg4 = seg_q[19:16];
    assign seg5 = seg_q[23:20];
    assign seg6 = seg_q[27:24];
    assign seg7 = seg_q[31:28];

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter with TICK_DIV=3 and DWELL=2. A behavioural
// model of ownership, dwell and prescaler runs beside the DUT. Directed
// scenarios also check constants taken from the intended behaviour.
module tb_display_arbiter;

    localparam logic [26:0] TICK_DIV = 27'd3;
    localparam logic [3:0]  DWELL    = 4'd2;

    logic        ck = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1, busy;
    logic [3:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [31:0] segs;

    int n_checks = 0;
    int n_fail   = 0;

    display_arbiter #(.TICK_DIV(TICK_DIV), .DWELL(DWELL), .BLANK(4'h0)) dut (
        .ck(ck), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
    );

    always #5 ck = ~ck;

    assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    // Reference model. Owner -1 means nobody owns the display.
    int          m_owner = -1;
    int          m_last  = 1;
    int          m_dwell = 0;
    int          m_tick  = 0;
    int          m_nxt;
    bit          m_t;
    bit          m_r[2];
    logic [1:0]  m_gnt = 2'b00;
    logic [31:0] m_seg = 32'h0;

    always @(posedge ck) begin
        if (rst) begin
            m_owner = -1; m_last = 1; m_dwell = 0; m_tick = 0;
        end else begin
            m_t    = (m_tick == int'(TICK_DIV));
            m_tick = m_t ? 0 : m_tick + 1;
            m_r[0] = req0;
            m_r[1] = req1;
            if (m_owner < 0) begin
                if (m_r[0] && m_r[1]) m_nxt = 1 - m_last;
                else if (m_r[0])      m_nxt = 0;
                else if (m_r[1])      m_nxt = 1;
                else                  m_nxt = -1;
            end else if (!m_r[m_owner]) begin
                m_nxt = m_r[1 - m_owner] ? 1 - m_owner : -1;
            end else if (m_r[1 - m_owner] && m_dwell == int'(DWELL)) begin
                m_nxt = 1 - m_owner;
            end else begin
                m_nxt = m_owner;
            end
            if (m_nxt < 0) m_dwell = 0;
            else if (m_nxt != m_owner) begin m_dwell = 0; m_last = m_nxt; end
            else if (m_t && m_dwell < int'(DWELL)) m_dwell = m_dwell + 1;
            m_owner = m_nxt;
        end
        m_gnt = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        m_seg = (m_owner == 0) ? data0 : (m_owner == 1) ? data1 : 32'h0;
    end

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 32'h0; data1 = 32'h0;
        step();
        n_checks++;
        if ({gnt1, gnt0, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt: got gnt1/gnt0/busy=%b expected 000", {gnt1, gnt0, busy});
        end
        n_checks++;
        if (segs !== 32'h0) begin
            n_fail++; $display("FAIL reset_segs: got %h expected 00000000", segs);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        req0 = 1'b1; data0 = 32'h8765_4321;
        step();
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_gnt: got gnt0=%b gnt1=%b busy=%b expected 1 0 1", gnt0, gnt1, busy);
        end
        n_checks++;
        if (seg0 !== 4'h1 || seg7 !== 4'h8 || segs !== 32'h8765_4321) begin
            n_fail++; $display("FAIL single_segs: got %h expected 87654321", segs);
        end
        req0 = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || segs !== 32'h0) begin
            n_fail++; $display("FAIL single_release: got busy=%b segs=%h expected 0 00000000", busy, segs);
        end
    endtask

    // Both request from IDLE after reset: requester 0 wins first. Each owner
    // then keeps the display for DWELL ticks (6..9 cycles at a 4-cycle tick).
    task automatic test_fairness();
        int cyc;
        bit seen;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 32'h1111_2222; data1 = 32'hABCD_EF01;
        step();
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL fair_first: got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
        end
        for (int leg = 0; leg < 2; leg++) begin
            cyc = 1; seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                step();
                n_checks++;
                if ({gnt1, gnt0} !== m_gnt || segs !== m_seg) begin
                    n_fail++; $display("FAIL fair_model: got gnt=%b segs=%h expected gnt=%b segs=%h", {gnt1, gnt0}, segs, m_gnt, m_seg);
                end
                if ((leg == 0) ? gnt1 : gnt0) seen = 1; else cyc++;
            end
            n_checks++;
            if (!seen || cyc < 6 || cyc > 9) begin
                n_fail++; $display("FAIL fair_dwell%0d: got seen=%0d owned %0d cycles expected 6..9", leg, seen, cyc);
            end
            n_checks++;
            if (segs !== ((leg == 0) ? data1 : data0)) begin
                n_fail++; $display("FAIL fair_segs%0d: got %h expected %h", leg, segs, (leg == 0) ? data1 : data0);
            end
        end
    endtask

    task automatic test_release();
        req0 = 1'b0; data0 = 32'h8765_4321;
        step();
        n_checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || segs !== data1) begin
            n_fail++; $display("FAIL release_handoff: got gnt=%b segs=%h expected 10 %h", {gnt1, gnt0}, segs, data1);
        end
        req1 = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || segs !== 32'h0) begin
            n_fail++; $display("FAIL release_idle: got busy=%b segs=%h expected 0 00000000", busy, segs);
        end
        req0 = 1'b1;
        step();
        n_checks++;
        if (gnt0 !== 1'b1 || segs !== 32'h8765_4321) begin
            n_fail++; $display("FAIL release_regrant: got gnt0=%b segs=%h expected 1 87654321", gnt0, segs);
        end
    endtask

    task automatic test_data_update();
        data0 = 32'hFFFF_FFFF;
        n_checks++;
        if (segs !== 32'h8765_4321) begin
            n_fail++; $display("FAIL update_before: got %h expected 87654321", segs);
        end
        step();
        n_checks++;
        if (segs !== 32'hFFFF_FFFF || gnt0 !== 1'b1) begin
            n_fail++; $display("FAIL update_after: got segs=%h gnt0=%b expected ffffffff 1", segs, gnt0);
        end
    endtask

    task automatic test_reset_mid_grant();
        req0 = 1'b0; req1 = 1'b1; data1 = 32'h5A5A_3C3C;
        step();
        n_checks++;
        if (gnt1 !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup: got gnt1=%b expected 1", gnt1);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({gnt1, gnt0, busy} !== 3'b000 || segs !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_idle: got gnt/busy=%b segs=%h expected 000 00000000", {gnt1, gnt0, busy}, segs);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (gnt1 !== 1'b1 || segs !== 32'h5A5A_3C3C) begin
            n_fail++; $display("FAIL rstmid_regrant: got gnt1=%b segs=%h expected 1 5a5a3c3c", gnt1, segs);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            if ($urandom_range(0, 3) == 0) data0 = $urandom;
            if ($urandom_range(0, 3) == 0) data1 = $urandom;
            rst = ($urandom_range(0, 99) == 0);
            step();
            n_checks++;
            if ({gnt1, gnt0} !== m_gnt || busy !== (m_gnt != 2'b00) || segs !== m_seg) begin
                n_fail++;
                $display("FAIL random_%0d: got gnt=%b busy=%b segs=%h expected gnt=%b segs=%h", i, {gnt1, gnt0}, busy, segs, m_gnt, m_seg);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_fairness();
        test_release();
        test_data_update();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
